l2_mem_arbiter: RTL and testbench



---
 rtl/l2_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_l2_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: round-robin arbiter sharing one single-port L2 SRAM between
// NumReq req/gnt requesters, with read responses routed back to their issuer.
// Optional feature: define L2_ARB_PERF_EN to build the request-conflict counter;
// otherwise conflict_cnt_o is tied to zero and no counter flops exist.
module l2_mem_arbiter #(
    parameter int unsigned  NumReq      = 2,
    parameter int unsigned  AddrWidth   = 32,
    parameter int unsigned  DataWidth   = 512,
    parameter int unsigned  SramLatency = 1,
    localparam int unsigned BeWidth     = DataWidth / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    output logic [NumReq-1:0]             gnt_o,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [NumReq*DataWidth-1:0]   rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [BeWidth-1:0]            mem_be_o,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    output logic [31:0]                   conflict_cnt_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    // Unpacked per-requester views so the winner can index them directly
    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [BeWidth-1:0]   be_arr    [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*AddrWidth +: AddrWidth];
        assign wdata_arr[g] = wdata_i[g*DataWidth +: DataWidth];
        assign be_arr[g]    = be_i[g*BeWidth +: BeWidth];
    end

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] winner;
    logic            found;

    // Search from the round-robin pointer upward (with wrap) for the first active request
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        winner   = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand     = (32'(ptr_q) + i) % NumReq;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // Drive the grant and SRAM request; both are forced low while reset is asserted
    always_comb begin
        gnt_o = '0;
        if (found && rst_ni) begin
            gnt_o[winner] = 1'b1;
        end
    end

    assign mem_req_o   = rst_ni & (|req_i);
    assign mem_we_o    = mem_req_o & we_i[winner];
    assign mem_addr_o  = addr_arr[winner];
    assign mem_wdata_o = wdata_arr[winner];
    assign mem_be_o    = be_arr[winner];

    if (NumReq == 1) begin : g_ptr_const
        assign ptr_q = '0;
    end else begin : g_ptr_rr
        // Advance the pointer past the winner on every grant; hold it when idle
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_q <= '0;
            end else if (mem_req_o) begin
                ptr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    // ---- in-flight tracking: stage 0 captures the accepted request, last stage meets rdata ----
    logic [SramLatency-1:0] vld_p;
    logic [IdxW-1:0]        idx_p [SramLatency];

    // Valid bits of the latency-matched shift register; cleared by reset to drop in-flight responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= mem_req_o;
            for (int i = 1; i < SramLatency; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Requester tags travel alongside the valid bits; they are only meaningful when valid
    always_ff @(posedge clk_i) begin
        idx_p[0] <= winner;
        for (int i = 1; i < SramLatency; i++) begin
            idx_p[i] <= idx_p[i-1];
        end
    end

    // Route the response valid (read data or write acknowledge) back to its issuer
    always_comb begin
        rvalid_o = '0;
        if (vld_p[SramLatency-1]) begin
            rvalid_o[idx_p[SramLatency-1]] = 1'b1;
        end
    end

    assign rdata_o = {NumReq{mem_rdata_i}};

`ifdef L2_ARB_PERF_EN
    logic [31:0] conflict_cnt_q;

    // Count cycles where two or more requesters compete, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
        end else if (($countones(req_i) >= 2) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Testbench for l2_mem_arbiter: a 2-requester/latency-1 instance driven from a
// vector table, and a 4-requester/latency-3 instance for tagging and reset cases.
module tb_l2_mem_arbiter;

`ifdef L2_ARB_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- DUT A: NumReq=2, SramLatency=1, DataWidth=512 ----------------
    logic          rst_a;
    logic [1:0]    req_a, gnt_a, we_a, rvalid_a;
    logic [63:0]   addr_a;
    logic [1023:0] wdata_a, rdata_a;
    logic [127:0]  be_a;
    logic          mem_req_a, mem_we_a;
    logic [31:0]   mem_addr_a, cnt_a;
    logic [511:0]  mem_wdata_a, mem_rdata_a;
    logic [63:0]   mem_be_a;

    l2_mem_arbiter #(.NumReq(2), .AddrWidth(32), .DataWidth(512), .SramLatency(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_a), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a),
        .we_i(we_a), .wdata_i(wdata_a), .be_i(be_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_be_o(mem_be_a), .mem_rdata_i(mem_rdata_a),
        .conflict_cnt_o(cnt_a)
    );

    // SRAM model A: 1-cycle read latency; unwritten words read as their address byte replicated
    logic [511:0] mem_a [256];
    logic [255:0] wr_a;
    logic         mem_clr;

    function automatic logic [511:0] expand_be(input logic [63:0] be);
        logic [511:0] m;
        for (int k = 0; k < 64; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            wr_a <= '0;
        end else if (mem_req_a) begin
            if (mem_we_a) begin
                mem_a[mem_addr_a[7:0]] <= (mem_a[mem_addr_a[7:0]] & ~expand_be(mem_be_a))
                                        | (mem_wdata_a & expand_be(mem_be_a));
                wr_a[mem_addr_a[7:0]]  <= 1'b1;
            end else begin
                mem_rdata_a <= wr_a[mem_addr_a[7:0]] ? mem_a[mem_addr_a[7:0]]
                                                     : {64{mem_addr_a[7:0]}};
            end
        end
    end

    // ---------------- DUT B: NumReq=4, SramLatency=3, DataWidth=32 ----------------
    logic          rst_b;
    logic [3:0]    req_b, gnt_b, we_b, rvalid_b;
    logic [127:0]  addr_b, wdata_b, rdata_b;
    logic [15:0]   be_b;
    logic          mem_req_b, mem_we_b;
    logic [31:0]   mem_addr_b, mem_wdata_b, mem_rdata_b, cnt_b;
    logic [3:0]    mem_be_b;
    logic [31:0]   rb0, rb1, rb2;

    l2_mem_arbiter #(.NumReq(4), .AddrWidth(32), .DataWidth(32), .SramLatency(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_b), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
        .we_i(we_b), .wdata_i(wdata_b), .be_i(be_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_be_o(mem_be_b), .mem_rdata_i(mem_rdata_b),
        .conflict_cnt_o(cnt_b)
    );

    // SRAM model B: 3-cycle read latency, contents are C0DE_0000 | address
    always @(posedge clk) begin
        rb0 <= 32'hC0DE_0000 | mem_addr_b;
        rb1 <= rb0;
        rb2 <= rb1;
    end
    assign mem_rdata_b = rb2;

    // ---------------- vector table for DUT A ----------------
    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] wb0;
        logic       do_rst;
        logic [1:0] gnt;
        logic [1:0] rv;
        logic       chk;
        logic [7:0] rd;
    } vec_t;

    vec_t tv [14];
    int   conf_exp;
    logic [3:0]  pend, exp_g, exp_rv;
    logic [31:0] exp_addr;

    initial begin
        //            req    we     a0     a1     wb0    rst   gnt    rv     chk   rd
        tv[0]  = '{2'b01, 2'b01, 8'h40, 8'h00, 8'hA5, 1'b0, 2'b01, 2'b00, 1'b0, 8'h00};
        tv[1]  = '{2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00};
        tv[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 8'hA5};
        tv[3]  = '{2'b11, 2'b00, 8'h40, 8'h80, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00};
        tv[4]  = '{2'b11, 2'b00, 8'h40, 8'h80, 8'h00, 1'b0, 2'b10, 2'b01, 1'b1, 8'hA5};
        tv[5]  = '{2'b11, 2'b00, 8'h40, 8'h80, 8'h00, 1'b0, 2'b01, 2'b10, 1'b1, 8'h80};
        tv[6]  = '{2'b11, 2'b00, 8'h40, 8'h80, 8'h00, 1'b0, 2'b10, 2'b01, 1'b1, 8'hA5};
        tv[7]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b10, 1'b1, 8'h80};
        tv[8]  = '{2'b10, 2'b00, 8'h00, 8'h80, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h00};
        tv[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b10, 1'b1, 8'h80};
        tv[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00};
        tv[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00};
        tv[12] = '{2'b11, 2'b00, 8'h40, 8'h80, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h00};
        tv[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 8'hA5};

        mem_clr = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '1;
        req_b = '0; we_b = '0; wdata_b = '0; be_b = '1;
        addr_b = {32'h40, 32'h30, 32'h20, 32'h10};
        conf_exp = 0;

        // Reset state, with requests asserted to show they are suppressed
        @(posedge clk); #1;
        req_a = 2'b11; req_b = 4'hF;
        @(negedge clk);
        check("rst_gnt_a", 512'(gnt_a), 512'(2'b00));
        check("rst_mem_req_a", 512'(mem_req_a), 512'(1'b0));
        check("rst_rvalid_a", 512'(rvalid_a), 512'(2'b00));
        check("rst_cnt_a", 512'(cnt_a), 512'(32'd0));
        check("rst_gnt_b", 512'(gnt_b), 512'(4'h0));
        @(posedge clk); #1;
        req_a = '0; req_b = '0;
        rst_a = 1'b1; rst_b = 1'b1; mem_clr = 1'b0;

        // Table-driven sequence on DUT A
        for (int v = 0; v < 14; v++) begin
            if (tv[v].do_rst) begin
                req_a = '0;
                rst_a = 1'b0;
                #2;
                rst_a = 1'b1;
                conf_exp = 0;
            end
            req_a   = tv[v].req;
            we_a    = tv[v].we;
            addr_a  = {24'h0, tv[v].a1, 24'h0, tv[v].a0};
            wdata_a = {{64{8'h00}}, {64{tv[v].wb0}}};
            @(negedge clk);
            check($sformatf("gnt_a[%0d]", v), 512'(gnt_a), 512'(tv[v].gnt));
            check($sformatf("rvalid_a[%0d]", v), 512'(rvalid_a), 512'(tv[v].rv));
            check($sformatf("mem_req_a[%0d]", v), 512'(mem_req_a), 512'(|tv[v].req));
            if (tv[v].gnt != 2'b00) begin
                exp_addr = tv[v].gnt[1] ? 32'(tv[v].a1) : 32'(tv[v].a0);
                check($sformatf("mem_addr_a[%0d]", v), 512'(mem_addr_a), 512'(exp_addr));
                check($sformatf("mem_we_a[%0d]", v), 512'(mem_we_a),
                      512'(tv[v].gnt[1] ? tv[v].we[1] : tv[v].we[0]));
            end
            if (tv[v].chk) begin
                check($sformatf("rdata_a[%0d]", v),
                      tv[v].rv[1] ? rdata_a[1023:512] : rdata_a[511:0], {64{tv[v].rd}});
            end
            check($sformatf("cnt_a[%0d]", v), 512'(cnt_a), 512'(PerfOn ? conf_exp : 0));
            @(posedge clk);
            if (tv[v].req == 2'b11) conf_exp++;
            #1;
        end

        // Perf counter: 10 cycles of contention, then 5 of a single requester
        req_a = '0; we_a = '0; addr_a = {32'h80, 32'h40};
        rst_a = 1'b0; #2; rst_a = 1'b1;
        for (int c = 0; c < 15; c++) begin
            req_a = (c < 10) ? 2'b11 : 2'b01;
            @(posedge clk); #1;
        end
        req_a = '0;
        @(negedge clk);
        check("perf_cnt_a", 512'(cnt_a), 512'(PerfOn ? 32'd10 : 32'd0));
        @(posedge clk); #1;

        // Tagging on DUT B: all four hold a read until granted
        pend = 4'hF;
        for (int c = 0; c < 7; c++) begin
            req_b = pend;
            @(negedge clk);
            exp_g  = (c < 4) ? 4'(1 << c) : 4'h0;
            exp_rv = (c >= 3) ? 4'(1 << (c - 3)) : 4'h0;
            check($sformatf("tag_gnt_b[%0d]", c), 512'(gnt_b), 512'(exp_g));
            check($sformatf("tag_rvalid_b[%0d]", c), 512'(rvalid_b), 512'(exp_rv));
            if (c >= 3) begin
                check($sformatf("tag_rdata_b[%0d]", c), 512'(rdata_b[(c-3)*32 +: 32]),
                      512'(32'hC0DE_0000 | 32'(16 * (c - 2))));
            end
            pend = pend & ~exp_g;
            @(posedge clk); #1;
        end

        // Reset mid-flight on DUT B: the granted read must never come back
        req_b = 4'b0001;
        @(negedge clk);
        check("mf_gnt_b", 512'(gnt_b), 512'(4'b0001));
        @(posedge clk); #1;
        req_b = 4'hF; rst_b = 1'b0;
        @(negedge clk);
        check("mf_rst_gnt_b", 512'(gnt_b), 512'(4'h0));
        check("mf_rst_mem_req_b", 512'(mem_req_b), 512'(1'b0));
        check("mf_rst_rvalid_b", 512'(rvalid_b), 512'(4'h0));
        @(posedge clk); #1;
        rst_b = 1'b1; req_b = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("mf_no_rvalid_b[%0d]", c), 512'(rvalid_b), 512'(4'h0));
            @(posedge clk); #1;
        end

        // Pointer is back at 0 after reset: requester 0 beats requester 3
        req_b = 4'b1001;
        @(negedge clk);
        check("post_rst_gnt_b", 512'(gnt_b), 512'(4'b0001));
        @(posedge clk); #1;
        req_b = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rvalid_b[%0d]", k), 512'(rvalid_b),
                  512'((k == 3) ? 4'b0001 : 4'b0000));
            if (k == 3) check("post_rst_rdata_b", 512'(rdata_b[31:0]), 512'(32'hC0DE_0010));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
